// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// the captured request record and the latency-counter width.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package data_mem_pkg;

    localparam int LAT_CNT_W  = 4;
    localparam int REQ_ADDR_W = `ADDR_SIZE;
    localparam int REQ_DATA_W = `DATA_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_e;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage for the data-memory responder: synchronous write,
// combinational read, full 2**ADDR_W depth.
module data_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage is deliberately not reset; only control state is, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request in, fixed LATENCY access, valid/ready response out.
// Define DATA_MEM_B2B_EN to accept a new request on the same edge as the response handshake.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W  = `ADDR_SIZE,
    parameter int DATA_W  = `DATA_SIZE,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);

    mem_state_e           state;
    mem_state_e           state_nxt;
    mem_req_t             req_q;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 req_fire;
    logic                 resp_fire;
    logic                 access;
    logic [DATA_W-1:0]    rd_data;

`ifdef DATA_MEM_B2B_EN
    assign req_ready = !rst && ((state == IDLE) || (state == RESP && resp_ready));
`else
    assign req_ready = !rst && (state == IDLE);
`endif

    assign req_fire   = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_fire  = resp_valid && resp_ready;
    assign busy       = (state != IDLE);

    // Every request passes through BUSY (LATENCY==1 enters with cnt already 0),
    // so resp_valid rises exactly LATENCY edges after acceptance.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    access    = 1'b1;
                end
            end
            RESP: begin
                if (resp_fire) begin
                    state_nxt = req_fire ? BUSY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            cnt        <= '0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (req_fire) begin
                req_q.write <= req_write;
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
                cnt         <= CNT_INIT;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Response fields change only on the access edge, so they hold through backpressure.
            if (access) begin
                resp_write <= req_q.write;
                resp_rdata <= req_q.write ? req_q.wdata : rd_data;
            end
        end
    end

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (access && req_q.write),
        .addr  (req_q.addr),
        .wdata (req_q.wdata),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table-driven transactions with a response
// scoreboard, plus backpressure, mid-operation reset, latency and back-to-back sequences.
`timescale 1ns/1ps

module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int AW = REQ_ADDR_W;
    localparam int DW = REQ_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_ready;

    logic          req_ready, resp_valid, resp_write, busy;
    logic [DW-1:0] resp_rdata;
    logic          l1_req_ready, l1_resp_valid, l1_resp_write, l1_busy;
    logic [DW-1:0] l1_resp_rdata;
    logic          l15_req_ready, l15_resp_valid, l15_resp_write, l15_busy;
    logic [DW-1:0] l15_resp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .busy(busy)
    );

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l1_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(l1_resp_valid), .resp_ready(resp_ready), .resp_write(l1_resp_write),
        .resp_rdata(l1_resp_rdata), .busy(l1_busy)
    );

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l15_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(l15_resp_valid), .resp_ready(resp_ready), .resp_write(l15_resp_write),
        .resp_rdata(l15_resp_rdata), .busy(l15_busy)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef DATA_MEM_B2B_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input int a, input logic [DW-1:0] d,
                                input logic [DW-1:0] e);
        vec_t v;
        v.write     = w;
        v.addr      = AW'(a);
        v.wdata     = d;
        v.exp_rdata = e;
        return v;
    endfunction

    // One complete transaction on the LATENCY=2 instance with resp_ready held high.
    task automatic do_txn(input vec_t v, input string tag);
        int   n;
        exp_t e;
        req_valid  = 1'b1;
        req_write  = v.write;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back('{write: v.write, rdata: v.exp_rdata});
        tick();
        req_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        if (resp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
            check({tag, "_resp_write"}, 64'(resp_write), 64'(e.write));
        end
        tick();
        check({tag, "_busy_after_resp"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int   n, lat_1, lat_2, lat_15, acc_n, hs_n, acc2_edge, hs1_edge;
        logic acc, hs, busy_dropped;
        exp_t e;

        vecs[0] = mk(1'b1, 3,             32'h0000_00A5, 32'h0000_00A5);
        vecs[1] = mk(1'b1, 2,             32'h0000_0000, 32'h0000_0000);
        vecs[2] = mk(1'b0, 3,             32'h0000_0000, 32'h0000_00A5);
        vecs[3] = mk(1'b1, 7,             32'hDEAD_BEEF, 32'hDEAD_BEEF);
        vecs[4] = mk(1'b0, 7,             32'h0000_0000, 32'hDEAD_BEEF);
        vecs[5] = mk(1'b1, (1 << AW) - 1, 32'h55AA_33CC, 32'h55AA_33CC);
        vecs[6] = mk(1'b1, 0,             32'h0F0F_0F0F, 32'h0F0F_0F0F);
        vecs[7] = mk(1'b0, (1 << AW) - 1, 32'h0000_0000, 32'h55AA_33CC);
        vecs[8] = mk(1'b0, 0,             32'h0000_0000, 32'h0F0F_0F0F);

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        tick();
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_resp_write", 64'(resp_write), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a competing store waits.
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(7); resp_ready = 1'b0;
        tick();
        req_write = 1'b1; req_wdata = 32'hBAD0_BAD0;
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_latency", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_resp_valid_%0d", i), 64'(resp_valid), 64'd1);
            check($sformatf("bp_rdata_%0d", i),      64'(resp_rdata), 64'hDEAD_BEEF);
            check($sformatf("bp_req_ready_%0d", i),  64'(req_ready),  64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("bp_released", 64'(busy), 64'd0);
        do_txn(mk(1'b0, 7, 32'h0, 32'hDEAD_BEEF), "bp_reload");

        // Reset during BUSY drops the store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(2); req_wdata = 32'h0000_1234;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",       64'(busy),       64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_req_ready",  64'(req_ready),  64'd0);
        check("mid_rst_resp_rdata", 64'(resp_rdata), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_txn(mk(1'b0, 2, 32'h0, 32'h0), "mid_rst_load");

        // Latency of the LATENCY=1/2/15 instances on the same request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(3); resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        lat_1 = -1; lat_2 = -1; lat_15 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (lat_1  < 0 && l1_resp_valid)  lat_1  = c;
            if (lat_2  < 0 && resp_valid)     lat_2  = c;
            if (lat_15 < 0 && l15_resp_valid) lat_15 = c;
        end
        check("lat1",  64'(lat_1),  64'd1);
        check("lat2",  64'(lat_2),  64'd2);
        check("lat15", 64'(lat_15), 64'd15);
        check("lat15_rdata", 64'(l15_resp_rdata), 64'h0000_00A5);
        resp_ready = 1'b1;
        tick();

        // Two loads with req_valid held high; scoreboard pushes on accept, pops on handshake.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sb.delete();
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(3); resp_ready = 1'b1;
        acc_n = 0; hs_n = 0; acc2_edge = -1; hs1_edge = -2; busy_dropped = 1'b0;
        for (int c = 0; c < 40 && hs_n < 2; c++) begin
            acc = req_valid && req_ready;
            hs  = resp_valid && resp_ready;
            if (hs) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("seq_rdata_%0d", hs_n), 64'(resp_rdata), 64'(e.rdata));
                end else begin
                    check("seq_unexpected_resp", 64'(hs), 64'd0);
                end
                hs_n++;
                if (hs_n == 1) hs1_edge = c;
            end
            if (acc) begin
                sb.push_back('{write: 1'b0,
                               rdata: (acc_n == 0) ? 32'h0000_00A5 : 32'hDEAD_BEEF});
                acc_n++;
                if (acc_n == 2) acc2_edge = c;
            end
            tick();
            if (acc_n == 1) req_addr = AW'(7);
            if (acc_n >= 2) req_valid = 1'b0;
            if (acc_n >= 1 && hs_n < 2 && !busy) busy_dropped = 1'b1;
        end
        req_valid = 1'b0;
        check("seq_two_responses",  64'(hs_n), 64'd2);
        check("seq_same_edge_b2b",  64'(acc2_edge == hs1_edge), 64'(B2B));
        check("seq_busy_dropped",   64'(busy_dropped), 64'(!B2B));
        check("seq_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
